pingpong_bank_ctrl: RTL and testbench

Controller for a two-bank ping-pong frame buffer placed between a producer layer (e.g. conv1, one word per valid cycle) and a consumer layer (e.g. 3x3 maxpool with its own read-address generator).
It generates producer write addresses and per-bank write enables, and tracks each bank's fill/drain state. It launches the consumer when a bank is full, steers consumer reads to the correct bank, and recycles banks on consumer completion.
It lets conv and pool overlap instead of running strictly write-then-read.

---
 rtl/pingpong_bank_ctrl_if.sv | 31 +++
 rtl/pingpong_bank_ctrl.sv | 117 +++++++++++
 tb/tb_pingpong_bank_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pingpong_bank_ctrl_if.sv
// Producer-write, consumer-read and status bundle of the ping-pong bank controller.
// The master modport is the controller side; the slave modport is the producer/consumer/bank side.
interface pingpong_bank_ctrl_if #(
  parameter int ADDR_W = 14
);
  logic              wr_valid;
  logic              prod_ready;
  logic              bank0_wren;
  logic              bank1_wren;
  logic [ADDR_W-1:0] wr_addr;
  logic              cons_valid;
  logic              cons_start;
  logic [ADDR_W-1:0] cons_rd_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_sel;
  logic              cons_done;
  logic              err;
  logic [15:0]       frames_done;

  modport master (
    input  wr_valid, cons_rd_addr, cons_done,
    output prod_ready, bank0_wren, bank1_wren, wr_addr, cons_valid, cons_start,
           rd_addr, rd_sel, err, frames_done
  );

  modport slave (
    output wr_valid, cons_rd_addr, cons_done,
    input  prod_ready, bank0_wren, bank1_wren, wr_addr, cons_valid, cons_start,
           rd_addr, rd_sel, err, frames_done
  );
endinterface

// File: rtl/pingpong_bank_ctrl.sv
// Two-bank ping-pong frame buffer controller: producer fill, consumer drain launch, bank recycling.
// Optional drained-frame counter enabled by macro PINGPONG_FRAME_CNT_EN.
module pingpong_bank_ctrl #(
  parameter int ADDR_W      = 14,
  parameter int FRAME_WORDS = 12321
) (
  input logic                  clk,
  input logic                  rst,
  pingpong_bank_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_st_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  bank_st_t          st_q [0:1];
  bank_st_t          st_d [0:1];
  logic              wp_q, wp_d;
  logic              rp_q, rp_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cv_q, cv_d;
  logic              cs_q, cs_d;
  logic              err_q, err_d;
  logic              prod_ready;
  logic              acc;
  logic              done_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q[0] <= EMPTY;
      st_q[1] <= EMPTY;
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      addr_q  <= '0;
      cv_q    <= 1'b0;
      cs_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      st_q[0] <= st_d[0];
      st_q[1] <= st_d[1];
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      addr_q  <= addr_d;
      cv_q    <= cv_d;
      cs_q    <= cs_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    st_d[0]    = st_q[0];
    st_d[1]    = st_q[1];
    wp_d       = wp_q;
    rp_d       = rp_q;
    addr_d     = addr_q;
    cv_d       = cv_q;
    cs_d       = 1'b0;
    err_d      = err_q;
    prod_ready = (st_q[wp_q] == EMPTY) || (st_q[wp_q] == FILLING);
    acc        = bus.wr_valid && prod_ready;
    done_acc   = bus.cons_done && cv_q;

    // Write side and read side touch different banks, so both updates apply independently.
    if (acc) begin
      if (addr_q == LAST_ADDR) begin
        st_d[wp_q] = FULL;
        addr_d     = '0;
        wp_d       = ~wp_q;
      end else begin
        st_d[wp_q] = FILLING;
        addr_d     = addr_q + ADDR_W'(1);
      end
    end

    if (bus.wr_valid && !prod_ready) err_d = 1'b1;
    if (bus.cons_done && !cv_q)      err_d = 1'b1;

    if (done_acc) begin
      st_d[rp_q] = EMPTY;
      rp_d       = ~rp_q;
      cv_d       = 1'b0;
    end else if (!cv_q && st_q[rp_q] == FULL) begin
      st_d[rp_q] = DRAINING;
      cv_d       = 1'b1;
      cs_d       = 1'b1;
    end
  end

  assign bus.prod_ready = prod_ready;
  assign bus.bank0_wren = acc && !wp_q;
  assign bus.bank1_wren = acc && wp_q;
  assign bus.wr_addr    = addr_q;
  assign bus.cons_valid = cv_q;
  assign bus.cons_start = cs_q;
  assign bus.rd_addr    = bus.cons_rd_addr;
  assign bus.rd_sel     = rp_q;
  assign bus.err        = err_q;

`ifdef PINGPONG_FRAME_CNT_EN
  logic [15:0] fcnt_q;

  always_ff @(posedge clk) begin
    if (rst)           fcnt_q <= '0;
    else if (done_acc) fcnt_q <= fcnt_q + 16'd1;
  end

  assign bus.frames_done = fcnt_q;
`else
  assign bus.frames_done = '0;
`endif

endmodule

// File: tb/tb_pingpong_bank_ctrl.sv
// Directed bench for pingpong_bank_ctrl with FRAME_WORDS=4; write accepts are checked against a scoreboard.
module tb_pingpong_bank_ctrl;
  localparam int AW = 4;
  localparam int FW = 4;

`ifdef PINGPONG_FRAME_CNT_EN
  localparam int FC_ON = 1;
`else
  localparam int FC_ON = 0;
`endif

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [5:0] exp_q[$];

  pingpong_bank_ctrl_if #(.ADDR_W(AW)) bus ();

  pingpong_bank_ctrl #(.ADDR_W(AW), .FRAME_WORDS(FW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected write: {bank1_wren, bank0_wren, wr_addr}
  task automatic push_wr(input bit b, input int a);
    logic [3:0] a4;
    a4 = a[3:0];
    exp_q.push_back({b, ~b, a4});
  endtask

  always @(negedge clk) begin
    if (!rst && (bus.bank0_wren || bus.bank1_wren)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wren", {26'd0, bus.bank1_wren, bus.bank0_wren, bus.wr_addr}, 32'd0);
      end else begin
        chk("wren_addr", {26'd0, bus.bank1_wren, bus.bank0_wren, bus.wr_addr},
            {26'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst              = 1'b1;
    bus.wr_valid     = 1'b0;
    bus.cons_done    = 1'b0;
    bus.cons_rd_addr = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_prod_ready", bus.prod_ready, 1);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_cons_valid", bus.cons_valid, 0);
    chk("rst_cons_start", bus.cons_start, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_rd_sel", bus.rd_sel, 0);
    chk("rst_frames", bus.frames_done, 0);

    // Test 1: continuous fill of bank0 then bank1
    bus.wr_valid = 1'b1;
    for (int i = 0; i < FW; i++) begin
      push_wr(0, i);
      tick();
    end
    push_wr(1, 0);
    chk("t1_no_start_early", bus.cons_start, 0);
    tick();
    chk("t1_cons_start", bus.cons_start, 1);
    chk("t1_cons_valid", bus.cons_valid, 1);
    chk("t1_rd_sel", bus.rd_sel, 0);
    for (int i = 1; i < FW; i++) begin
      push_wr(1, i);
      tick();
      if (i == 1) chk("t1_start_pulse", bus.cons_start, 0);
    end
    chk("t1_prod_ready_low", bus.prod_ready, 0);
    chk("t1_wr_addr_wrap", bus.wr_addr, 0);
    chk("t1_err_clean", bus.err, 0);

    // Test 2: producer pushes while both banks are occupied
    tick();
    tick();
    tick();
    chk("t2_err", bus.err, 1);
    chk("t2_prod_ready", bus.prod_ready, 0);
    chk("t2_cons_valid", bus.cons_valid, 1);
    bus.wr_valid = 1'b0;

    // Test 3: finish bank0 drain, bank1 drain follows, producer refills bank0
    bus.cons_done = 1'b1;
    tick();
    bus.cons_done = 1'b0;
    chk("t3_cons_valid_low", bus.cons_valid, 0);
    chk("t3_rd_sel", bus.rd_sel, 1);
    chk("t3_prod_ready", bus.prod_ready, 1);
    chk("t3_err_sticky", bus.err, 1);
    bus.wr_valid = 1'b1;
    push_wr(0, 0);
    tick();
    chk("t3_cons_start", bus.cons_start, 1);
    chk("t3_cons_valid", bus.cons_valid, 1);
    chk("t3_rd_sel_drain", bus.rd_sel, 1);
    bus.cons_rd_addr = 4'hA;
    #1;
    chk("t3_rd_addr_pass", bus.rd_addr, 4'hA);
    for (int i = 1; i < FW; i++) begin
      push_wr(0, i);
      tick();
    end
    chk("t3_prod_ready_low", bus.prod_ready, 0);

    // Test 4: final write into bank1 coincides with bank0 drain completion
    bus.wr_valid  = 1'b0;
    bus.cons_done = 1'b1;
    tick();
    bus.cons_done = 1'b0;
    chk("t4_cons_valid_low", bus.cons_valid, 0);
    chk("t4_rd_sel0", bus.rd_sel, 0);
    chk("t4_prod_ready", bus.prod_ready, 1);
    bus.wr_valid = 1'b1;
    push_wr(1, 0);
    tick();
    chk("t4_start_bank0", bus.cons_start, 1);
    chk("t4_rd_sel_b0", bus.rd_sel, 0);
    push_wr(1, 1);
    tick();
    push_wr(1, 2);
    tick();
    push_wr(1, 3);
    bus.cons_done = 1'b1;
    tick();
    bus.cons_done = 1'b0;
    bus.wr_valid  = 1'b0;
    chk("t4_cons_valid_low2", bus.cons_valid, 0);
    chk("t4_bank0_free", bus.prod_ready, 1);
    chk("t4_rd_sel1", bus.rd_sel, 1);
    chk("t4_no_start_yet", bus.cons_start, 0);
    chk("t4_frames", bus.frames_done, FC_ON ? 3 : 0);
    tick();
    chk("t4_start_bank1", bus.cons_start, 1);
    chk("t4_rd_sel1_drain", bus.rd_sel, 1);

    // Test 5: reset in the middle of a fill
    bus.wr_valid = 1'b1;
    push_wr(0, 0);
    tick();
    push_wr(0, 1);
    tick();
    chk("t5_wr_addr_mid", bus.wr_addr, 2);
    bus.wr_valid = 1'b0;
    rst          = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_wr_addr", bus.wr_addr, 0);
    chk("t5_cons_valid", bus.cons_valid, 0);
    chk("t5_err", bus.err, 0);
    chk("t5_prod_ready", bus.prod_ready, 1);
    chk("t5_rd_sel", bus.rd_sel, 0);
    chk("t5_frames", bus.frames_done, 0);
    bus.wr_valid = 1'b1;
    for (int i = 0; i < FW; i++) begin
      push_wr(0, i);
      tick();
    end
    push_wr(1, 0);
    chk("t5_no_start_early", bus.cons_start, 0);
    tick();
    bus.wr_valid = 1'b0;
    chk("t5_cons_start", bus.cons_start, 1);
    chk("t5_rd_sel_drain", bus.rd_sel, 0);

    // Test 6: accepted done counts, spurious done flags err only
    bus.cons_done = 1'b1;
    tick();
    chk("t6_cons_valid_low", bus.cons_valid, 0);
    chk("t6_err_clean", bus.err, 0);
    chk("t6_frames_one", bus.frames_done, FC_ON ? 1 : 0);
    tick();
    bus.cons_done = 1'b0;
    chk("t6_err_spurious", bus.err, 1);
    chk("t6_frames_hold", bus.frames_done, FC_ON ? 1 : 0);
    chk("t6_no_launch", bus.cons_start, 0);
    tick();
    tick();
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
